// File: rtl/mfp_gpio_pkg.sv
// Shared definitions for the mfp_ahb_gpio_irq GPIO slave: register indices
// (HADDR[4:2]) and the AHB HTRANS IDLE encoding.
package mfp_gpio_pkg;

  typedef enum logic [2:0] {
    GPIO_IN_DATA   = 3'd0,
    GPIO_OUT_DATA  = 3'd1,
    GPIO_OUT_SET   = 3'd2,
    GPIO_OUT_CLR   = 3'd3,
    GPIO_EDGE_STAT = 3'd4,
    GPIO_IRQ_EN    = 3'd5,
    GPIO_EDGE_RISE = 3'd6,
    GPIO_EDGE_FALL = 3'd7
  } gpio_reg_e;

  localparam logic [1:0] HTRANS_IDLE = 2'b00;

endpackage

// File: rtl/mfp_gpio_in_chan.sv
// Single GPIO input channel: 2-flop synchroniser, optional debounce
// (macro MFP_GPIO_DEBOUNCE_EN), previous-value flop and edge pulses.
module mfp_gpio_in_chan #(
  parameter int unsigned DB_CYCLES = 50000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic din_i,
  output logic lvl_o,
  output logic rise_o,
  output logic fall_o
);

  logic sync1_q, sync2_q, prev_q;
  logic lvl;

  // Two-stage synchroniser for the asynchronous pin.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= din_i;
      sync2_q <= sync1_q;
    end
  end

`ifdef MFP_GPIO_DEBOUNCE_EN
  localparam int unsigned CW = (DB_CYCLES < 2) ? 1 : $clog2(DB_CYCLES);

  logic [CW-1:0] cnt_q;
  logic          db_q;

  // Debounced level follows the synchronised value only after it has
  // differed for DB_CYCLES consecutive cycles; any agreement restarts the count.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      db_q  <= 1'b0;
    end else if (sync2_q == db_q) begin
      cnt_q <= '0;
    end else if (cnt_q == CW'(DB_CYCLES - 1)) begin
      cnt_q <= '0;
      db_q  <= sync2_q;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign lvl = db_q;
`else
  logic [31:0] unused_db_cycles;
  assign unused_db_cycles = DB_CYCLES;
  assign lvl = sync2_q;
`endif

  // Previous-value flop used for edge detection.
  always_ff @(posedge clk_i) begin
    if (rst_i) prev_q <= 1'b0;
    else       prev_q <= lvl;
  end

  assign lvl_o  = lvl;
  assign rise_o = lvl & ~prev_q;
  assign fall_o = ~lvl & prev_q;

endmodule

// File: rtl/mfp_ahb_gpio_irq.sv
// AHB-Lite GPIO slave with per-channel edge status, interrupt mask and
// atomic set/clear on outputs. Optional input debounce: MFP_GPIO_DEBOUNCE_EN.
module mfp_ahb_gpio_irq
  import mfp_gpio_pkg::*;
#(
  parameter int unsigned       N_IN      = 16,
  parameter int unsigned       N_OUT     = 16,
  parameter logic [N_OUT-1:0]  OUT_RST   = '0,
  parameter int unsigned       DB_CYCLES = 50000
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic [4:0]        HADDR,
  input  logic [1:0]        HTRANS,
  input  logic [31:0]       HWDATA,
  input  logic              HWRITE,
  input  logic              HSEL,
  output logic [31:0]       HRDATA,
  input  logic [N_IN-1:0]   GPIO_IN,
  output logic [N_OUT-1:0]  GPIO_OUT,
  output logic              IRQ
);

  logic [N_IN-1:0]  in_lvl, in_rise, in_fall;

  logic             wr_pend_q;
  gpio_reg_e        wr_idx_q;

  logic [N_OUT-1:0] out_q, out_d;
  logic [N_IN-1:0]  stat_q, stat_d;
  logic [N_IN-1:0]  en_q, en_d;
  logic [N_IN-1:0]  rise_q, rise_d;
  logic [N_IN-1:0]  fall_q, fall_d;
  logic [N_IN-1:0]  w1c;
  logic             irq_q;
  logic [31:0]      rdata_q, rdata_d;

  logic [N_IN-1:0]  wd_in;
  logic [N_OUT-1:0] wd_out;
  logic             rd_req;
  logic             unused_ok;

  assign wd_in     = HWDATA[N_IN-1:0];
  assign wd_out    = HWDATA[N_OUT-1:0];
  assign rd_req    = HSEL && (HTRANS != HTRANS_IDLE) && !HWRITE;
  assign unused_ok = ^{HADDR[1:0], HWDATA};

  for (genvar i = 0; i < N_IN; i++) begin : g_in_chan
    mfp_gpio_in_chan #(
      .DB_CYCLES(DB_CYCLES)
    ) u_chan (
      .clk_i (HCLK),
      .rst_i (HRESET),
      .din_i (GPIO_IN[i]),
      .lvl_o (in_lvl[i]),
      .rise_o(in_rise[i]),
      .fall_o(in_fall[i])
    );
  end

  // Capture the address phase so the write can commit in the data phase.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      wr_pend_q <= 1'b0;
      wr_idx_q  <= GPIO_IN_DATA;
    end else begin
      wr_pend_q <= HSEL && HWRITE && (HTRANS != HTRANS_IDLE);
      wr_idx_q  <= gpio_reg_e'(HADDR[4:2]);
    end
  end

  // Next-state of all writable registers; new edges win over W1C.
  always_comb begin
    out_d  = out_q;
    en_d   = en_q;
    rise_d = rise_q;
    fall_d = fall_q;
    w1c    = '0;
    if (wr_pend_q) begin
      case (wr_idx_q)
        GPIO_OUT_DATA:  out_d  = wd_out;
        GPIO_OUT_SET:   out_d  = out_q | wd_out;
        GPIO_OUT_CLR:   out_d  = out_q & ~wd_out;
        GPIO_EDGE_STAT: w1c    = wd_in;
        GPIO_IRQ_EN:    en_d   = wd_in;
        GPIO_EDGE_RISE: rise_d = wd_in;
        GPIO_EDGE_FALL: fall_d = wd_in;
        default: ;
      endcase
    end
    stat_d = (stat_q & ~w1c) | (in_rise & rise_q) | (in_fall & fall_q);
  end

  // Register file update and registered interrupt.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      out_q  <= OUT_RST;
      stat_q <= '0;
      en_q   <= '0;
      rise_q <= '0;
      fall_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      out_q  <= out_d;
      stat_q <= stat_d;
      en_q   <= en_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      irq_q  <= |(stat_q & en_q);
    end
  end

  // Read mux uses next-state values, so a write committing on this same
  // edge (write followed by read of the same register) is forwarded.
  always_comb begin
    rdata_d = '0;
    case (gpio_reg_e'(HADDR[4:2]))
      GPIO_IN_DATA:   rdata_d[N_IN-1:0]  = in_lvl;
      GPIO_OUT_DATA:  rdata_d[N_OUT-1:0] = out_d;
      GPIO_EDGE_STAT: rdata_d[N_IN-1:0]  = stat_d;
      GPIO_IRQ_EN:    rdata_d[N_IN-1:0]  = en_d;
      GPIO_EDGE_RISE: rdata_d[N_IN-1:0]  = rise_d;
      GPIO_EDGE_FALL: rdata_d[N_IN-1:0]  = fall_d;
      default: ;
    endcase
  end

  // Registered read data; holds when no read is in progress.
  always_ff @(posedge HCLK) begin
    if (HRESET)      rdata_q <= '0;
    else if (rd_req) rdata_q <= rdata_d;
  end

  assign HRDATA   = rdata_q;
  assign GPIO_OUT = out_q;
  assign IRQ      = irq_q;

endmodule

// File: tb/tb_mfp_ahb_gpio_irq.sv
// Self-checking bench for mfp_ahb_gpio_irq: reads are scored against a
// behavioural register model through an expectation queue.
module tb_mfp_ahb_gpio_irq;

`ifdef MFP_GPIO_DEBOUNCE_EN
  localparam int STAT_LAT = 2 + 4;
`else
  localparam int STAT_LAT = 2;
`endif

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic [4:0]  HADDR;
  logic [1:0]  HTRANS;
  logic [31:0] HWDATA;
  logic        HWRITE;
  logic        HSEL;
  logic [31:0] HRDATA;
  logic [15:0] GPIO_IN;
  logic [15:0] GPIO_OUT;
  logic        IRQ;

  always #5 HCLK = ~HCLK;

  mfp_ahb_gpio_irq #(
    .N_IN(16), .N_OUT(16), .OUT_RST(16'h00A5), .DB_CYCLES(4)
  ) dut (
    .HCLK(HCLK), .HRESET(HRESET), .HADDR(HADDR), .HTRANS(HTRANS),
    .HWDATA(HWDATA), .HWRITE(HWRITE), .HSEL(HSEL), .HRDATA(HRDATA),
    .GPIO_IN(GPIO_IN), .GPIO_OUT(GPIO_OUT), .IRQ(IRQ)
  );

  int n_chk  = 0;
  int n_pass = 0;
  logic [31:0] exp_q[$];

  // Behavioural model of the register file (settled values).
  logic [15:0] m_in, m_out, m_stat, m_en, m_rise, m_fall;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", nm, act, exp);
  endtask

  function automatic logic [31:0] model_rd(input logic [2:0] idx);
    case (idx)
      3'd0:    return {16'h0, m_in};
      3'd1:    return {16'h0, m_out};
      3'd4:    return {16'h0, m_stat};
      3'd5:    return {16'h0, m_en};
      3'd6:    return {16'h0, m_rise};
      3'd7:    return {16'h0, m_fall};
      default: return 32'h0;
    endcase
  endfunction

  function automatic void model_wr(input logic [2:0] idx, input logic [31:0] d);
    case (idx)
      3'd1: m_out  = d[15:0];
      3'd2: m_out  = m_out | d[15:0];
      3'd3: m_out  = m_out & ~d[15:0];
      3'd4: m_stat = m_stat & ~d[15:0];
      3'd5: m_en   = d[15:0];
      3'd6: m_rise = d[15:0];
      3'd7: m_fall = d[15:0];
      default: ;
    endcase
  endfunction

  // Monitor: a read address phase seen at a clock edge means HRDATA is due.
  logic rd_pend = 1'b0;
  always @(posedge HCLK)
    rd_pend <= !HRESET && HSEL && (HTRANS != 2'b00) && !HWRITE;

  always @(negedge HCLK) begin
    if (rd_pend) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL rd_unexpected: got %h required no read", HRDATA);
      end else begin
        chk("rd_data", HRDATA, exp_q.pop_front());
      end
    end
  end

  task automatic idle();
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
  endtask

  task automatic wr(input logic [2:0] idx, input logic [31:0] d);
    @(negedge HCLK);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = {idx, 2'b00};
    @(negedge HCLK);
    idle(); HWDATA = d;
    @(negedge HCLK);
    model_wr(idx, d);
  endtask

  task automatic rd(input logic [2:0] idx);
    @(negedge HCLK);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0; HADDR = {idx, 2'b00};
    exp_q.push_back(model_rd(idx));
    @(negedge HCLK);
    idle();
  endtask

  task automatic wr_rd(input logic [2:0] idx, input logic [31:0] d);
    @(negedge HCLK);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = {idx, 2'b00};
    @(negedge HCLK);
    HWRITE = 1'b0; HWDATA = d;
    model_wr(idx, d);
    exp_q.push_back(model_rd(idx));
    @(negedge HCLK);
    idle();
    @(negedge HCLK);
  endtask

  task automatic settle();
    @(negedge HCLK);
    chk("gpio_out", {16'h0, GPIO_OUT}, {16'h0, m_out});
    chk("irq", {31'h0, IRQ}, {31'h0, |(m_stat & m_en)});
  endtask

  task automatic set_in(input logic [15:0] v);
    @(negedge HCLK);
    m_stat = m_stat | (m_rise & ~m_in & v) | (m_fall & m_in & ~v);
    m_in = v;
    GPIO_IN = v;
    repeat (12) @(negedge HCLK);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1);
  end

  initial begin
    logic [15:0] v;
    HRESET = 1'b1; idle(); HADDR = '0; HWDATA = '0; GPIO_IN = 16'h5A3C;
    m_in = 16'h5A3C; m_out = 16'h00A5; m_stat = '0; m_en = '0; m_rise = '0; m_fall = '0;
    repeat (3) @(negedge HCLK);
    chk("rst_gpio_out", {16'h0, GPIO_OUT}, 32'h0000_00A5);
    chk("rst_irq", {31'h0, IRQ}, 32'h0);
    chk("rst_hrdata", HRDATA, 32'h0);
    HRESET = 1'b0;

    // Reset arriving in the data phase aborts the write.
    @(negedge HCLK);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = {3'd1, 2'b00};
    @(negedge HCLK);
    idle(); HWDATA = 32'h0000_FFFF; HRESET = 1'b1;
    @(negedge HCLK);
    HRESET = 1'b0;
    @(negedge HCLK);
    chk("rst_abort_out", {16'h0, GPIO_OUT}, 32'h0000_00A5);
    repeat (12) @(negedge HCLK);
    rd(3'd0);

    // Output register, set and clear.
    wr(3'd1, 32'h0000_1234);
    chk("out_data", {16'h0, GPIO_OUT}, 32'h0000_1234);
    rd(3'd1);
    wr(3'd2, 32'h0000_000F);
    chk("out_set", {16'h0, GPIO_OUT}, 32'h0000_123F);
    rd(3'd1);
    wr(3'd3, 32'h0000_0200);
    chk("out_clr", {16'h0, GPIO_OUT}, 32'h0000_103F);
    rd(3'd1); rd(3'd2); rd(3'd3);

    // Rising edge on channel 0 -> status, then IRQ one cycle later.
    wr(3'd6, 32'h1);
    wr(3'd5, 32'h1);
    @(negedge HCLK);
    GPIO_IN[0] = 1'b1;
    repeat (STAT_LAT + 1) @(negedge HCLK);
    chk("irq_lat_low", {31'h0, IRQ}, 32'h0);
    @(negedge HCLK);
    chk("irq_lat_high", {31'h0, IRQ}, 32'h1);
    m_in[0] = 1'b1; m_stat[0] = 1'b1;
    repeat (10) @(negedge HCLK);
    rd(3'd4);
    wr(3'd4, 32'h1);
    settle();

    // New edge and W1C of the same bit on one edge: status stays set.
    set_in(m_in & ~16'h1);
    set_in(m_in | 16'h1);
    set_in(m_in & ~16'h1);
    settle();
    @(negedge HCLK);
    GPIO_IN[0] = 1'b1;
    repeat (STAT_LAT - 1) @(negedge HCLK);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = {3'd4, 2'b00};
    @(negedge HCLK);
    idle(); HWDATA = 32'h1;
    @(negedge HCLK);
    chk("same_cyc_irq0", {31'h0, IRQ}, 32'h1);
    @(negedge HCLK);
    chk("same_cyc_irq1", {31'h0, IRQ}, 32'h1);
    m_in[0] = 1'b1;
    repeat (10) @(negedge HCLK);
    rd(3'd4);
    wr(3'd4, 32'h1);
    settle();

    // Write immediately followed by a read of the same register.
    wr_rd(3'd5, 32'h0000_FFFF);
    rd(3'd2);
    settle();

`ifdef MFP_GPIO_DEBOUNCE_EN
    wr(3'd6, 32'h3);
    set_in(m_in & ~16'h2);
    @(negedge HCLK);
    GPIO_IN[1] = 1'b1;
    repeat (3) @(negedge HCLK);
    GPIO_IN[1] = 1'b0;
    repeat (12) @(negedge HCLK);
    rd(3'd4);
    @(negedge HCLK);
    GPIO_IN[1] = 1'b1;
    repeat (6) @(negedge HCLK);
    GPIO_IN[1] = 1'b0;
    repeat (12) @(negedge HCLK);
    m_stat[1] = 1'b1;
    rd(3'd4);
    settle();
`endif

    // Randomised mix of bus traffic and input changes.
    for (int i = 0; i < 250; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: wr(3'($urandom_range(0, 7)), $urandom);
        4, 5, 6:    rd(3'($urandom_range(0, 7)));
        7:          wr_rd(3'($urandom_range(0, 7)), $urandom);
        8: begin
          v = 16'($urandom);
          set_in(v);
        end
        default: ;
      endcase
      settle();
    end

    repeat (3) @(negedge HCLK);
    if (exp_q.size() != 0) begin
      n_chk++;
      $display("FAIL rd_missing: got %0d outstanding required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mfp_ahb_gpio_irq.md
Name: mfp_ahb_gpio_irq

Overview:
Parametrised AHB-Lite GPIO slave, the next generation of the board GPIO block. It provides N_IN synchronised input channels (switches, pushbuttons) and N_OUT output channels (LEDs, bot control). Each input has per-channel edge detection, sticky edge status and an interrupt mask, combined into one level IRQ. Outputs support atomic set/clear writes. It sits on the AHB bus decoder beside the other mfp_ahb_* slaves.

Parameters:
N_IN, 16, number of input channels (1..32)
N_OUT, 16, number of output channels (1..32)
OUT_RST, 0, reset value of the output register (N_OUT bits)
DB_CYCLES, 50000, debounce stable-count (used only with the optional feature)

Ports:
HCLK  in  1  bus clock; sole clock
HRESET  in  1  reset; one clock; reset is synchronous and active-high
HADDR  in  5  byte address; register index = HADDR[4:2]
HTRANS  in  2  AHB transfer type
HWDATA  in  32  write data (data phase)
HWRITE  in  1  write/read
HSEL  in  1  slave select
HRDATA  out  32  registered read data
GPIO_IN  in  N_IN  asynchronous external inputs
GPIO_OUT  out  N_OUT  output register
IRQ  out  1  OR of (EDGE_STAT & IRQ_EN), registered

Behaviour:
- Register map (index: name, access):
  - 0 IN_DATA, RO, synchronised inputs.
  - 1 OUT_DATA, RW.
  - 2 OUT_SET, WO, write-1-sets OUT_DATA bits.
  - 3 OUT_CLR, WO, write-1-clears OUT_DATA bits.
  - 4 EDGE_STAT, RW1C.
  - 5 IRQ_EN, RW.
  - 6 EDGE_RISE, RW, 1 = rising-edge detect per channel.
  - 7 EDGE_FALL, RW, 1 = falling-edge detect per channel.
  - Rising and falling may both be enabled on one channel.
- Reset (sync, HRESET=1 at a HCLK edge):
  - GPIO_OUT=OUT_RST.
  - HRDATA=0, IRQ=0.
  - EDGE_STAT, IRQ_EN, EDGE_RISE, EDGE_FALL = 0.
  - Synchroniser and previous-value flops = 0.
  - Reset mid-transfer aborts it; no write commits.
- Input path:
  - 2-flop synchroniser, then a previous-value flop.
  - IN_DATA reflects a GPIO_IN change 2 cycles after it.
  - Edge event is detected in the cycle sync != prev; EDGE_STAT bit sets on the next edge.
- Writes:
  - Address-phase HADDR/HWRITE/HSEL/HTRANS are registered.
  - Commit when the registered HSEL & HWRITE & HTRANS != IDLE, using HWDATA in the data phase.
  - Write visible on outputs the cycle after the data phase.
  - Writes to IN_DATA are ignored.
  - Bits above N_IN/N_OUT are ignored.
- Reads:
  - HRDATA is registered from the address-phase HADDR every cycle HSEL & HTRANS != IDLE & !HWRITE; valid in the data phase (zero wait states).
  - OUT_SET/OUT_CLR read as 0.
  - Unused upper bits read 0.
  - With no read in progress, HRDATA holds its value.
- Simultaneous events:
  - New edge and W1C on the same EDGE_STAT bit in the same cycle: set wins.
  - Write to OUT_DATA with both a previous SET and CLR pending is impossible; one commit per cycle.
- IRQ:
  - Registered, one cycle after the EDGE_STAT/IRQ_EN change.
  - Stays high until all enabled status bits are cleared.
- Back-to-back transfers (write then read of the same register): read returns the newly written value. The write commits at the end of the read's address phase and a bypass forwards it.

Optional Feature:
Macro MFP_GPIO_DEBOUNCE_EN.
- Defined: each input channel gets a counter after the synchroniser. The debounced value changes only after the synchronised value has differed from it for DB_CYCLES consecutive cycles. IN_DATA and edge detection use the debounced value. Counters reset to 0.
- Undefined: no counters; latency as above.

Decomposition:
- Package mfp_gpio_pkg holds:
  - Register index constants: GPIO_IN_DATA, GPIO_OUT_DATA, GPIO_OUT_SET, GPIO_OUT_CLR, GPIO_EDGE_STAT, GPIO_IRQ_EN, GPIO_EDGE_RISE, GPIO_EDGE_FALL.
  - HTRANS_IDLE.
- One sub-module: mfp_gpio_in_chan (synchroniser, optional debounce, edge detect) for a single bit, instantiated N_IN times by generate.

Test Plan:
- Reset with OUT_RST=16'h00A5 -> GPIO_OUT=00A5, IRQ=0, read IN_DATA = current inputs after 2 cycles.
- Write OUT_DATA=0x1234, OUT_SET=0x000F, OUT_CLR=0x0200 -> GPIO_OUT 0x1234 -> 0x123F -> 0x103F; reads match.
- EDGE_RISE=0x0001, IRQ_EN=0x0001; GPIO_IN[0] 0->1 -> EDGE_STAT=0x1 after 3 cycles, IRQ=1 one cycle later; write 0x1 to EDGE_STAT -> IRQ=0.
- Same-cycle new edge on bit 0 and W1C of bit 0 -> EDGE_STAT[0] stays 1, IRQ stays 1.
- Write IRQ_EN=0xFFFF then immediately read IRQ_EN -> HRDATA=0x0000FFFF; read OUT_SET -> 0.
- MFP_GPIO_DEBOUNCE_EN, DB_CYCLES=4: 3-cycle glitch on GPIO_IN[1] -> no EDGE_STAT change; 6-cycle pulse -> EDGE_STAT[1] sets.
